// File: rtl/clkmeter_pkg.sv
// Shared types and default constants for the clock period meter.
package clkmeter_pkg;

    localparam int DEF_CNT_W       = 25;
    localparam int DEF_EXPECTED    = 16666670;
    localparam int DEF_TOL         = 16;
    localparam int DEF_TIMEOUT     = 33333340;
    localparam int DEF_LOCK_COUNT  = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int LOCK_W          = 3;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOST       = 2'd2
    } meter_state_t;

    // Saturating good-period run length; any bad period restarts the run.
    function automatic logic [LOCK_W-1:0] lock_step(
        input logic [LOCK_W-1:0] cnt,
        input logic              good,
        input logic [LOCK_W-1:0] limit
    );
        logic [LOCK_W-1:0] nxt;
        if (!good) begin
            nxt = 3'd0;
        end else if (cnt >= limit) begin
            nxt = limit;
        end else begin
            nxt = cnt + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/clk_sync_edge.sv
// Multi-stage synchronizer for an asynchronous clock with rise/fall strobes.
module clk_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic input_clock,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // synchronizer chain plus one cycle of history on its output
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign fall = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/clock_period_meter.sv
// Period/lock/timeout monitor for a slow asynchronous clock.
// Define CLKMETER_DUTY_EN to add the high_time output.
module clock_period_meter
    import clkmeter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int EXPECTED    = DEF_EXPECTED,
    parameter int TOL         = DEF_TOL,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             input_clock,
    input  logic             reset,
    input  logic             measured_clock,
    output logic [CNT_W-1:0] period,
`ifdef CLKMETER_DUTY_EN
    output logic [CNT_W-1:0] high_time,
`endif
    output logic             period_valid,
    output logic             in_range,
    output logic             locked,
    output logic             timeout_flag
);

    localparam logic [CNT_W-1:0]        CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic signed [CNT_W:0]   EXP_S        = (CNT_W+1)'(EXPECTED);
    localparam logic [CNT_W:0]          TOL_U        = (CNT_W+1)'(TOL);
    localparam logic [LOCK_W-1:0]       LOCK_MAX     = LOCK_W'(LOCK_COUNT);

    meter_state_t          state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [LOCK_W-1:0]     lock_cnt_r;
    logic                  rise_s;
    logic                  fall_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic signed [CNT_W:0] diff_s;
    logic [CNT_W:0]        abs_diff_s;
    logic                  good_s;
    logic [LOCK_W-1:0]     lock_next_s;

    clk_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .input_clock(input_clock),
        .reset      (reset),
        .async_in   (measured_clock),
        .rise       (rise_s),
        .fall       (fall_s)
    );

    // candidate period and its distance from nominal, one bit wider for sign
    always_comb begin
        cnt_inc_s = cnt_r + CNT_ONE;
        diff_s    = $signed({1'b0, cnt_inc_s}) - EXP_S;
        if (diff_s[CNT_W]) begin
            abs_diff_s = $unsigned(-diff_s);
        end else begin
            abs_diff_s = $unsigned(diff_s);
        end
        good_s      = (abs_diff_s <= TOL_U);
        lock_next_s = lock_step(lock_cnt_r, good_s, LOCK_MAX);
    end

    // measurement FSM; a rise always beats the timeout threshold
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            state_r      <= WAIT_FIRST;
            cnt_r        <= CNT_ZERO;
            lock_cnt_r   <= 3'd0;
            period       <= CNT_ZERO;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            locked       <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state_r)
                WAIT_FIRST: begin
                    cnt_r <= CNT_ZERO;
                    if (rise_s) begin
                        state_r <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_s) begin
                        period       <= cnt_inc_s;
                        period_valid <= 1'b1;
                        in_range     <= good_s;
                        lock_cnt_r   <= lock_next_s;
                        locked       <= (lock_next_s == LOCK_MAX);
                        cnt_r        <= CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r      <= LOST;
                        timeout_flag <= 1'b1;
                        in_range     <= 1'b0;
                        locked       <= 1'b0;
                        lock_cnt_r   <= 3'd0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                LOST: begin
                    if (rise_s) begin
                        state_r      <= MEASURE;
                        cnt_r        <= CNT_ZERO;
                        timeout_flag <= 1'b0;
                    end
                end
                default: begin
                    state_r <= WAIT_FIRST;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

`ifdef CLKMETER_DUTY_EN
    logic [CNT_W-1:0] high_len_r;
    logic             fall_seen_r;

    // capture the first fall after each rise; no fall means high for the whole period
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            high_time   <= CNT_ZERO;
            high_len_r  <= CNT_ZERO;
            fall_seen_r <= 1'b0;
        end else begin
            case (state_r)
                MEASURE: begin
                    if (rise_s) begin
                        high_time   <= fall_seen_r ? high_len_r : cnt_inc_s;
                        fall_seen_r <= 1'b0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        high_time   <= CNT_ZERO;
                        fall_seen_r <= 1'b0;
                    end else if (fall_s && !fall_seen_r) begin
                        high_len_r  <= cnt_inc_s;
                        fall_seen_r <= 1'b1;
                    end
                end
                default: begin
                    high_time   <= CNT_ZERO;
                    fall_seen_r <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_fall_s;
    assign unused_fall_s = fall_s;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter; duty checks active under CLKMETER_DUTY_EN.
`timescale 1ns/1ps
module tb_clock_period_meter;

    localparam int CNT_W       = 8;
    localparam int EXPECTED    = 20;
    localparam int TOL         = 1;
    localparam int TIMEOUT     = 40;
    localparam int LOCK_COUNT  = 3;
    localparam int SYNC_STAGES = 2;

    logic             input_clock = 1'b0;
    logic             reset = 1'b1;
    logic             measured_clock = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_range;
    logic             locked;
    logic             timeout_flag;
`ifdef CLKMETER_DUTY_EN
    logic [CNT_W-1:0] high_time;
`endif

    typedef struct {
        int   per;
        logic ir;
        logic lk;
        int   ht;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   last_rise = 0;
    bit   have_prev = 1'b0;
    int   model_lock = 0;
    int   prev_hi = 0;
    int   last_per = 0;
    logic prev_valid = 1'b0;

    clock_period_meter #(
        .CNT_W(CNT_W), .EXPECTED(EXPECTED), .TOL(TOL), .TIMEOUT(TIMEOUT),
        .LOCK_COUNT(LOCK_COUNT), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .input_clock   (input_clock),
        .reset         (reset),
        .measured_clock(measured_clock),
        .period        (period),
`ifdef CLKMETER_DUTY_EN
        .high_time     (high_time),
`endif
        .period_valid  (period_valid),
        .in_range      (in_range),
        .locked        (locked),
        .timeout_flag  (timeout_flag)
    );

    always #5 input_clock = ~input_clock;

    always @(posedge input_clock) cyc_cnt <= cyc_cnt + 1;

    // scoreboard: pop an expectation on every reported period
    always @(negedge input_clock) begin
        prev_valid <= period_valid;
        if (!reset && period_valid) begin
            n_checks++;
            if (prev_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_back_valid: period_valid high on consecutive cycles");
            end
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got period=%0d, required no report", period);
            end else begin
                mon_e = sb_q.pop_front();
                n_checks++;
                if (period !== CNT_W'(mon_e.per)) begin
                    n_fail++;
                    $display("FAIL period: got %0d, required %0d", period, mon_e.per);
                end
                n_checks++;
                if (in_range !== mon_e.ir) begin
                    n_fail++;
                    $display("FAIL in_range: got %b, required %b (period %0d)", in_range, mon_e.ir, mon_e.per);
                end
                n_checks++;
                if (locked !== mon_e.lk) begin
                    n_fail++;
                    $display("FAIL locked: got %b, required %b (period %0d)", locked, mon_e.lk, mon_e.per);
                end
                n_checks++;
                if (timeout_flag !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_on_valid: got %b, required 0", timeout_flag);
                end
`ifdef CLKMETER_DUTY_EN
                n_checks++;
                if (high_time !== CNT_W'(mon_e.ht)) begin
                    n_fail++;
                    $display("FAIL high_time: got %0d, required %0d", high_time, mon_e.ht);
                end
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge input_clock);
        #1;
    endtask

    // reference model: decide at each driven rise what the DUT must report
    task automatic note_rise(input int hi);
        int   el;
        exp_t e;
        el = cyc_cnt - last_rise;
        if (have_prev && el <= TIMEOUT) begin
            e.per = el;
            e.ir  = ((el - EXPECTED) <= TOL) && ((EXPECTED - el) <= TOL);
            if (e.ir) model_lock = (model_lock < LOCK_COUNT) ? model_lock + 1 : LOCK_COUNT;
            else      model_lock = 0;
            e.lk = (model_lock == LOCK_COUNT);
            e.ht = prev_hi;
            last_per = el;
            sb_q.push_back(e);
        end else if (have_prev) begin
            model_lock = 0;
        end
        have_prev = 1'b1;
        last_rise = cyc_cnt;
        prev_hi   = hi;
    endtask

    task automatic drive_wave(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            note_rise(hi);
            measured_clock = 1'b1;
            cyc(hi);
            measured_clock = 1'b0;
            cyc(per - hi);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        measured_clock = 1'b0;
        cyc(3);
        n_checks++;
        if (period !== 8'd0 || period_valid !== 1'b0 || in_range !== 1'b0 ||
            locked !== 1'b0 || timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got period=%0d valid=%b in_range=%b locked=%b timeout=%b, required all 0",
                     period, period_valid, in_range, locked, timeout_flag);
        end
`ifdef CLKMETER_DUTY_EN
        n_checks++;
        if (high_time !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_high_time: got %0d, required 0", high_time);
        end
`endif
        reset = 1'b0;
        have_prev = 1'b0;
        model_lock = 0;
        cyc(2);
    endtask

    task automatic test_basic_lock();
        drive_wave(20, 10, 6);
    endtask

    task automatic test_out_of_range();
        drive_wave(22, 11, 1);
        drive_wave(20, 10, 4);
    endtask

    task automatic test_timeout();
        int c;
        c = last_rise;
        repeat (c + 42 - cyc_cnt) @(posedge input_clock);
        #1;
        n_checks++;
        if (timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got %b, required 0", timeout_flag);
        end
        n_checks++;
        if (locked !== (model_lock == LOCK_COUNT)) begin
            n_fail++;
            $display("FAIL locked_before_timeout: got %b, required %b", locked, model_lock == LOCK_COUNT);
        end
        cyc(1);
        n_checks++;
        if (timeout_flag !== 1'b1 || locked !== 1'b0 || in_range !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: got timeout=%b locked=%b in_range=%b, required 1 0 0",
                     timeout_flag, locked, in_range);
        end
        n_checks++;
        if (period !== CNT_W'(last_per)) begin
            n_fail++;
            $display("FAIL period_held: got %0d, required %0d", period, last_per);
        end
        cyc(5);
        note_rise(10);
        measured_clock = 1'b1;
        cyc(2);
        n_checks++;
        if (timeout_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_clear_early: got %b, required 1", timeout_flag);
        end
        cyc(1);
        n_checks++;
        if (timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b, required 0", timeout_flag);
        end
        cyc(7);
        measured_clock = 1'b0;
        cyc(10);
        drive_wave(20, 10, 2);
    endtask

    task automatic test_boundary_40();
        drive_wave(40, 20, 3);
    endtask

    task automatic test_reset_mid();
        note_rise(10);
        measured_clock = 1'b1;
        cyc(10);
        measured_clock = 1'b0;
        cyc(2);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_before_reset: got %0d outstanding, required 0", sb_q.size());
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (period !== 8'd0 || in_range !== 1'b0 || locked !== 1'b0 || timeout_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got period=%0d in_range=%b locked=%b timeout=%b, required all 0",
                     period, in_range, locked, timeout_flag);
        end
        repeat (3) @(posedge input_clock);
        #2;
        reset = 1'b0;
        have_prev = 1'b0;
        model_lock = 0;
        cyc(3);
        drive_wave(20, 10, 4);
    endtask

    task automatic test_duty();
        drive_wave(20, 7, 4);
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_out_of_range();
        test_timeout();
        test_boundary_40();
        test_reset_mid();
`ifdef CLKMETER_DUTY_EN
        test_duty();
`endif
        cyc(8);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_reports: got %0d outstanding, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
